// File: rtl/hivek_normalizer.sv
// Purpose: iterative leading/trailing-bit counter (clz/ctz/cls/pass) for the execute stage.
// Latency: result valid exactly log2(WIDTH) edges after the accepting edge.
// Backpressure: result held stable while ready_i=0; a new operand may be accepted on the draining edge.
// Optional: define HIVEK_NORMALIZER_NORM_EN to add the normalized-value output norm_o.
module hivek_normalizer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] value_i,
    input  logic [1:0]       kind,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o
`ifdef HIVEK_NORMALIZER_NORM_EN
    ,
    output logic [WIDTH-1:0] norm_o
`endif
);

    localparam int STEPS = $clog2(WIDTH);
    localparam int SW    = STEPS;

    localparam logic [1:0] K_CLZ  = 2'b00;
    localparam logic [1:0] K_CTZ  = 2'b01;
    localparam logic [1:0] K_CLS  = 2'b10;
    localparam logic [1:0] K_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [SW-1:0]    step_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       kind_q;

    logic             accept;
    logic [WIDTH-1:0] rev_val;
    logic [WIDTH-1:0] xform_val;
    logic [CNT_W-1:0] step_k;
    logic [WIDTH-1:0] top_mask;
    logic             take;
    logic [WIDTH-1:0] work_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             last_step;
    logic             all_zero;
    logic [CNT_W-1:0] cnt_final;

    // Ready while idle, or while draining a finished result so back-to-back operands overlap the hand-off.
    assign ready_o = (state == ST_IDLE) || ((state == ST_DONE) && ready_i);
    assign accept  = valid_i && ready_o;

    // Bit-reverse the operand so ctz reuses the leading-zero search.
    always_comb begin
        rev_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_val[i] = value_i[WIDTH-1-i];
        end
    end

    // Map every kind onto a leading-zero search of the transformed operand.
    always_comb begin
        xform_val = value_i;
        case (kind)
            K_CLZ:   xform_val = value_i;
            K_CTZ:   xform_val = rev_val;
            K_CLS:   xform_val = value_i ^ {WIDTH{value_i[WIDTH-1]}};
            default: xform_val = value_i;
        endcase
    end

    // One halving step: step size WIDTH/2, WIDTH/4, ... 1; shift out the top k bits when they are all zero.
    always_comb begin
        step_k    = CNT_W'(WIDTH / 2) >> step_q;
        top_mask  = ~({WIDTH{1'b1}} >> step_k);
        take      = (kind_q != K_PASS) && ((work_q & top_mask) == '0);
        work_nx   = take ? (work_q << step_k) : work_q;
        cnt_nx    = take ? (cnt_q + step_k) : cnt_q;
        last_step = (step_q == SW'(STEPS - 1));
        // A nonzero operand is fully normalized after the last step, so a clear MSB means the operand was zero.
        all_zero  = (kind_q != K_PASS) && !work_nx[WIDTH-1];
        cnt_final = all_zero ? CNT_W'(WIDTH) : cnt_nx;
    end

    // Control FSM plus search datapath; result registers hold in DONE until the consumer takes them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            step_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            kind_q  <= '0;
            valid_o <= 1'b0;
            count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_SEARCH;
                        step_q <= '0;
                        work_q <= xform_val;
                        cnt_q  <= '0;
                        kind_q <= kind;
                    end
                end
                ST_SEARCH: begin
                    work_q <= work_nx;
                    cnt_q  <= cnt_nx;
                    step_q <= step_q + SW'(1);
                    if (last_step) begin
                        state   <= ST_DONE;
                        valid_o <= 1'b1;
                        count_o <= cnt_final;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (valid_i) begin
                            state  <= ST_SEARCH;
                            step_q <= '0;
                            work_q <= xform_val;
                            cnt_q  <= '0;
                            kind_q <= kind;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIVEK_NORMALIZER_NORM_EN
    logic [WIDTH-1:0] nwork_q;
    logic [WIDTH-1:0] nwork_nx;

    // Shift the untransformed operand in lockstep with the search; ctz shifts the other way.
    always_comb begin
        nwork_nx = nwork_q;
        if (take) begin
            nwork_nx = (kind_q == K_CTZ) ? (nwork_q >> step_k) : (nwork_q << step_k);
        end
    end

    // Normalized-value register, loaded at the same edge as count_o and held with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nwork_q <= '0;
            norm_o  <= '0;
        end else if (accept) begin
            nwork_q <= value_i;
        end else if (state == ST_SEARCH) begin
            nwork_q <= nwork_nx;
            if (last_step) begin
                norm_o <= all_zero ? '0 : nwork_nx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hivek_normalizer.sv
module tb_hivek_normalizer;

    localparam int W     = 64;
    localparam int STEPS = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] value_i;
    logic [1:0]  kind;
    logic        valid_o;
    logic        ready_i;
    logic [6:0]  count_o;
`ifdef HIVEK_NORMALIZER_NORM_EN
    logic [63:0] norm_o;
`endif

    hivek_normalizer #(.WIDTH(64), .CNT_W(7)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .value_i (value_i),
        .kind    (kind),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .count_o (count_o)
`ifdef HIVEK_NORMALIZER_NORM_EN
        ,
        .norm_o  (norm_o)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count and normalized value straight from the instruction definitions.
    function automatic void ref_calc(input logic [1:0] k, input logic [63:0] v,
                                     output int c, output logic [63:0] n);
        bit stop;
        c = 0;
        stop = 0;
        case (k)
            2'b00: for (int i = W - 1; i >= 0; i--) begin
                if (!stop) begin
                    if (v[i] == 1'b0) c++; else stop = 1;
                end
            end
            2'b01: for (int i = 0; i < W; i++) begin
                if (!stop) begin
                    if (v[i] == 1'b0) c++; else stop = 1;
                end
            end
            2'b10: for (int i = W - 1; i >= 0; i--) begin
                if (!stop) begin
                    if (v[i] == v[W-1]) c++; else stop = 1;
                end
            end
            default: c = 0;
        endcase
        if (k == 2'b11)      n = v;
        else if (c == W)     n = '0;
        else if (k == 2'b01) n = v >> c;
        else                 n = v << c;
    endfunction

    // Transaction-level model of the handshake: result appears STEPS edges after accept, leaves when taken.
    bit          m_pending = 0;
    bit          m_valid = 0;
    int          m_rem = 0;
    int          m_count = 0;
    logic [63:0] m_norm = '0;
    int          p_count = 0;
    logic [63:0] p_norm = '0;

    initial begin
        bit acc;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_pending = 0;
                m_valid   = 0;
                m_rem     = 0;
            end else begin
                acc = valid_i && !m_pending && (!m_valid || ready_i);
                if (m_pending) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_pending = 0;
                        m_valid   = 1;
                        m_count   = p_count;
                        m_norm    = p_norm;
                    end
                end else if (m_valid && ready_i) begin
                    m_valid = 0;
                end
                if (acc) begin
                    m_pending = 1;
                    m_rem     = STEPS;
                    ref_calc(kind, value_i, p_count, p_norm);
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
                chk("ready_o", {63'd0, ready_o}, {63'd0, (!m_pending && (!m_valid || ready_i))});
                if (m_valid) begin
                    chk("count_o", {57'd0, count_o}, 64'(m_count));
`ifdef HIVEK_NORMALIZER_NORM_EN
                    chk("norm_o", norm_o, m_norm);
`endif
                end
            end
        end
    end

    function automatic logic [63:0] rand_val();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return r;
            3: return r >> $urandom_range(0, 63);
            4: return r << $urandom_range(0, 63);
            default: return ~(r >> $urandom_range(0, 63));
        endcase
    endfunction

    // Issue one operand (entered at posedge+1), check exact latency and the literal result.
    task automatic run_op(input logic [1:0] k, input logic [63:0] v, input int exp_c,
                          input logic [63:0] exp_n, input bit hold_ready, input bit expect_now);
        int waited;
        bit ok;
        waited  = 0;
        ok      = 0;
        valid_i = 1'b1;
        kind    = k;
        value_i = v;
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clock);
            #1;
            waited++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'(waited), 64'd0);
        end else begin
            if (expect_now) chk("ready_same_cycle", 64'(waited), 64'd0);
            @(posedge clock);
            #1;
            valid_i = 1'b0;
            value_i = {$urandom, $urandom};
            kind    = 2'($urandom_range(0, 3));
            ready_i = !hold_ready;
            chk("valid_after_accept", {63'd0, valid_o}, 64'd0);
            repeat (STEPS - 1) @(posedge clock);
            #1;
            chk("latency_early", {63'd0, valid_o}, 64'd0);
            @(posedge clock);
            #1;
            chk("latency_valid", {63'd0, valid_o}, 64'd1);
            chk("count_literal", {57'd0, count_o}, 64'(exp_c));
`ifdef HIVEK_NORMALIZER_NORM_EN
            chk("norm_literal", norm_o, exp_n);
`endif
        end
    endtask

    initial begin
        bit ok;
        reset   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        kind    = 2'b00;
        value_i = '0;
        #2;
        chk("reset_valid_o", {63'd0, valid_o}, 64'd0);
        chk("reset_count_o", {57'd0, count_o}, 64'd0);
        chk("reset_ready_o", {63'd0, ready_o}, 64'd1);
`ifdef HIVEK_NORMALIZER_NORM_EN
        chk("reset_norm_o", norm_o, 64'd0);
`endif
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_op(2'b00, 64'h0000_0000_0000_0001, 63, 64'h8000_0000_0000_0000, 0, 0);
        run_op(2'b00, 64'h0, 64, 64'h0, 0, 0);
        run_op(2'b01, 64'h0, 64, 64'h0, 0, 0);
        run_op(2'b11, 64'h1234, 0, 64'h1234, 0, 0);
        run_op(2'b01, 64'h0000_0000_0000_0100, 8, 64'h1, 0, 0);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FF00, 56, 64'h0, 0, 0);
        run_op(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h0, 0, 0);

        // Backpressure: result must sit unchanged for a long stall, then overlap with the next accept.
        run_op(2'b01, 64'h0000_0000_0000_0100, 8, 64'h1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("stall_valid", {63'd0, valid_o}, 64'd1);
            chk("stall_count", {57'd0, count_o}, 64'd8);
        end
        run_op(2'b00, 64'h1, 63, 64'h8000_0000_0000_0000, 0, 1);

        // Reset in the middle of a search aborts it immediately.
        @(posedge clock);
        #1;
        valid_i = 1'b1;
        kind    = 2'b00;
        value_i = 64'h0000_0000_0001_0000;
        ready_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) chk("reset_test_accept", {63'd0, ready_o}, 64'd1);
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid_o", {63'd0, valid_o}, 64'd0);
        chk("abort_ready_o", {63'd0, ready_o}, 64'd1);
        chk("abort_count_o", {57'd0, count_o}, 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_op(2'b00, 64'h00FF_0000_0000_0000, 8, 64'hFF00_0000_0000_0000, 0, 0);

        // Random traffic against the model, with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            kind    = 2'($urandom_range(0, 3));
            value_i = rand_val();
            if (i == 1500) begin
                #2;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) @(posedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
